// File: rtl/imem_prog.sv
// Programmable instruction memory. It serves registered single-cycle fetches and
// accepts run-time loading through a streaming program port (IDLE/LOAD FSM).
module imem_prog #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int ADDR_W = WORD_W - OP_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_data,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic              prog_valid,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_busy,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count,
  output logic              prog_wrap
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic fetch;
  logic fetch_in_range;
  logic ptr_in_range;

  // A fetch is refused while loading or when a load starts this cycle.
  assign if_ready       = (state == IDLE) && !prog_start;
  assign fetch          = if_req && if_ready;
  assign fetch_in_range = {1'b0, if_addr} < DEPTH_C;
  assign ptr_in_range   = {1'b0, ptr} < DEPTH_C;
  assign prog_busy      = (state == LOAD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      if_valid   <= 1'b0;
      if_data    <= '0;
      prog_done  <= 1'b0;
      prog_count <= '0;
      prog_wrap  <= 1'b0;
      // NOTE: the memory is cleared on reset, so it is built from flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      prog_done <= 1'b0;
      if_valid  <= fetch;
      if (fetch) if_data <= fetch_in_range ? mem[if_addr] : '0;

      case (state)
        IDLE: begin
          if (prog_start) begin
            state      <= LOAD;
            ptr        <= prog_base;
            prog_count <= '0;
            prog_wrap  <= 1'b0;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            if (ptr_in_range) mem[ptr] <= prog_data;
            if (ptr == LAST_ADDR) begin
              ptr       <= '0;
              prog_wrap <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
            if (prog_count != DEPTH_C) prog_count <= prog_count + 1'b1;
            if (prog_last) begin
              state     <= IDLE;
              prog_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_prog.md
# imem_prog

Programmable instruction memory for the basic processor, the parametrised successor to the fixed-program instruction ROM. It holds DEPTH words of WORD_W bits, serves instruction fetches through a registered request/valid handshake, and is loaded at run time through a streaming program port driven by a small state machine. It sits between the processor's program counter and the host/loader that downloads programs.

## Interface

- WORD_W, 8, instruction word width (opcode plus address field).
- OP_W, 3, opcode field width; address field is WORD_W-OP_W.
- ADDR_W, WORD_W-OP_W, address width.
- DEPTH, 2**ADDR_W, number of words; must be ≤ 2**ADDR_W.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request.
- if_addr  input  ADDR_W  fetch address.
- if_ready  output  1  fetch can be accepted this cycle.
- if_valid  output  1  if_data holds a fetched word (one-cycle pulse).
- if_data  output  WORD_W  fetched instruction.
- prog_start  input  1  begin programming at prog_base.
- prog_base  input  ADDR_W  first address written.
- prog_valid  input  1  prog_data is a word to store.
- prog_data  input  WORD_W  word to store.
- prog_last  input  1  qualifies the final word, with prog_valid.
- prog_busy  output  1  programming in progress.
- prog_done  output  1  one-cycle pulse after the last word is written.
- prog_count  output  ADDR_W+1  words written in the current/last session.
- prog_wrap  output  1  sticky: write address wrapped past DEPTH-1.

## Operation

- States: IDLE, LOAD. Reset → IDLE.
- Reset: all DEPTH words cleared to 0; if_valid=0, if_data=0, prog_busy=0, prog_done=0, prog_count=0, prog_wrap=0.
- if_ready = (state==IDLE) && !prog_start (combinational).
- Fetch accepted when if_req && if_ready; mem[if_addr] captured into if_data, if_valid=1 for the next cycle. Otherwise if_valid=0 and if_data holds its last value.
- if_addr ≥ DEPTH: fetch accepted, if_data=0.
- IDLE → LOAD on prog_start: write pointer ← prog_base, prog_count ← 0, prog_wrap ← 0.
- prog_start in the same cycle as if_req: programming wins, fetch not accepted.
- LOAD: each cycle with prog_valid, mem[ptr] ← prog_data, ptr increments, prog_count increments. At ptr==DEPTH-1 the next pointer is 0 and prog_wrap is set (sticky until the next prog_start or reset).
- prog_valid && prog_last in LOAD: word written, → IDLE, prog_done=1 next cycle.
- prog_valid=0 in LOAD: no write, remain in LOAD (stall allowed indefinitely).
- prog_start while in LOAD: ignored.
- prog_valid/prog_last in IDLE: ignored, no write.
- prog_busy = (state==LOAD).
- prog_count saturates at DEPTH (counts writes; overwrites after wrap still count up to DEPTH).
- Reset mid-LOAD: returns to IDLE, memory cleared, partial program discarded, no prog_done.

## Timing

- Fetch latency: 1 cycle (request edge N → if_valid/if_data at N+1). Back-to-back fetches each cycle give one word per cycle.
- Program write: takes effect at the edge where prog_valid is sampled. A fetch of that address accepted one cycle after return to IDLE returns the new word.
- prog_start edge N: prog_busy=1 from N+1; first write earliest at edge N+1.
- Last word at edge M: prog_busy=0 and prog_done=1 during M+1; if_ready=1 during M+1.
- No read-during-write case: fetches are blocked throughout LOAD.

## Test plan

- Reset, then fetch addr 0..31 (WORD_W=8) → if_valid one cycle after each request, if_data=0 for all.
- prog_start with base 0, stream 8'h1E, 8'h3E, 8'h5F, 8'h1E, 8'hA1 with prog_last on the 5th → prog_done pulse, prog_count=5, prog_wrap=0; fetch 0..4 returns the same words in order, addr 5 returns 0.
- Base 30, stream 4 words 8'h11..8'h14 → words at 30, 31, 0, 1; prog_wrap=1; prog_count=4.
- prog_start and if_req asserted together → if_ready=0, no if_valid next cycle, prog_busy=1.
- Gaps: prog_valid low for 3 cycles mid-stream → no writes during the gaps, prog_count unchanged, final contents correct.
- Reset asserted after 2 of 5 words → state IDLE, prog_busy=0, no prog_done, fetch of base returns 0.
